tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Sequential 1:NUM_CH demultiplexer for a time-division-multiplexed serial bit stream.
//  Each strobed input bit is steered into its channel slot; a frame sync marks slot 0.
//  A completed frame is published in parallel with a one-cycle valid pulse.
//  This is the receive end for a 16:1 mux-style serializer; it feeds parallel consumers.
// PARAMETERS
//  NUM_CH  16                  channels (slots) per frame; must be >= 2
//  SLOT_W  $clog2(NUM_CH+1)    slot counter width
// PORTS
//  clk_i           in   1       system clock, all logic on rising edge
//  rst_i           in   1       synchronous, active-high reset
//  data_i          in   1       serial TDM bit
//  bit_valid_i     in   1       strobe: data_i/frame_i sampled only when high
//  frame_i         in   1       frame sync, high with the slot-0 bit
//  ch_data_o       out  NUM_CH  last complete frame, bit k = channel k
//  frame_valid_o   out  1       1-cycle pulse: ch_data_o just updated
//  slot_o          out  SLOT_W  slot index the next strobed bit will occupy
//  locked_o        out  1       1 = in LOCKED state
//  sync_err_o      out  1       1-cycle pulse on frame-sync violation
//  parity_err_o    out  1       1-cycle pulse on parity failure (tied 0 without macro)
// BEHAVIOUR
//  Reset: ch_data_o=0, frame_valid_o=0, slot_o=0, locked_o=0, sync_err_o=0,
//   parity_err_o=0, shadow register=0, state=HUNT. Reset mid-frame discards the partial frame.
//  Cycles with bit_valid_i=0: no state change, pulses deassert.
//  HUNT: strobes with frame_i=0 ignored. Strobe with frame_i=1: data_i -> shadow[0],
//   slot_o=1, -> LOCKED.
//  LOCKED, strobe at slot s (0<s<FRAME_LEN-1), frame_i=0: data_i -> shadow[s], slot_o=s+1.
//  LOCKED, strobe at last slot, frame_i=0: ch_data_o <= {data_i-merged shadow}, frame_valid_o=1
//   next cycle, slot_o=0. Latency: ch_data_o visible 1 cycle after the last-slot strobe.
//  LOCKED, strobe at slot 0 with frame_i=0: sync_err_o pulse, -> HUNT, slot_o=0, bit dropped.
//  LOCKED, strobe at slot s!=0 with frame_i=1: sync_err_o pulse, partial frame dropped,
//   bit taken as new slot 0 (shadow[0]=data_i, slot_o=1), stays LOCKED.
//  ch_data_o holds its value until the next good frame; it never shows partial frames.
//  Back-to-back strobes every cycle are supported at full rate; no stall.
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined: FRAME_LEN=NUM_CH+1; final slot NUM_CH carries even parity
//   over the NUM_CH data bits. Match -> publish as above. Mismatch -> ch_data_o held,
//   frame_valid_o=0, parity_err_o pulses 1 cycle, slot_o=0, remains LOCKED.
//  Undefined: FRAME_LEN=NUM_CH, no parity slot, parity_err_o tied 0.
// STRUCTURE
//  Package tdm_pkg: state enum {HUNT, LOCKED}; function computing FRAME_LEN;
//   parity helper function.
//  Sub-module tdm_slot_counter: slot counter with load-1, clear and wrap at FRAME_LEN-1.
//  Top holds the FSM, shadow register, output register and pulse logic.
// TESTING
//  1 Reset, then 16 strobes of 0xA5C3 (LSB first) with frame_i on bit 0 -> ch_data_o=16'hA5C3,
//    frame_valid_o high exactly 1 cycle after the 16th strobe, locked_o=1.
//  2 Strobes before any frame_i -> ignored; slot_o=0, locked_o=0, ch_data_o=0.
//  3 Two back-to-back frames 0x1234, 0xFFFF at 1 strobe/cycle -> two valid pulses 16 cycles
//    apart, values in order.
//  4 frame_i asserted at slot 7 -> sync_err_o pulse; the following 16 bits from that point publish.
//    Frame with frame_i=0 at slot 0 -> sync_err_o pulse, locked_o=0.
//  5 rst_i at slot 9 -> all outputs 0 next cycle; earlier published value cleared.
//  6 PARITY_EN: 0x0001 + parity 1 -> published; 0x0001 + parity 0 -> parity_err_o pulse,
//    ch_data_o unchanged.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// TDM_DEMUX_PARITY_EN appends an even-parity slot to every frame.
package tdm_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    function automatic int frame_len(input int num_ch);
`ifdef TDM_DEMUX_PARITY_EN
        return num_ch + 1;
`else
        return num_ch;
`endif
    endfunction

    // Callers zero-extend; channel counts above 64 are not supported.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter: clear, load-1 on sync, wrap after the last slot.
// Priority is reset, clear, load-1, increment.
module tdm_slot_counter #(
    parameter int SLOT_W    = 5,
    parameter int FRAME_LEN = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o
);

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(FRAME_LEN - 1);

    logic [SLOT_W-1:0] slot_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else if (clr_i) begin
            slot_q <= '0;
        end else if (load1_i) begin
            slot_q <= SLOT_W'(1);
        end else if (inc_i) begin
            slot_q <= (slot_q == LAST) ? '0 : slot_q + 1'b1;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM receiver: steers strobed bits into channel slots, publishes frames.
// TDM_DEMUX_PARITY_EN adds a trailing even-parity slot checked before publish.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int SLOT_W = $clog2(NUM_CH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_i,
    input  logic              bit_valid_i,
    input  logic              frame_i,
    output logic [NUM_CH-1:0] ch_data_o,
    output logic              frame_valid_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              locked_o,
    output logic              sync_err_o,
    output logic              parity_err_o
);

    localparam int FRAME_LEN = frame_len(NUM_CH);
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] shadow_q;
    logic [NUM_CH-1:0] pub_data;
    logic [NUM_CH-1:0] ch_data_q;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] wr_idx;
    logic              clr, load1, inc, wr_en, publish;
    logic              sync_err_d, par_err_d;
    logic              frame_valid_q, sync_err_q;

    tdm_slot_counter #(
        .SLOT_W   (SLOT_W),
        .FRAME_LEN(FRAME_LEN)
    ) u_slot (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .load1_i(load1),
        .inc_i  (inc),
        .slot_o (slot)
    );

`ifdef TDM_DEMUX_PARITY_EN
    assign pub_data = shadow_q;
`else
    // The last data bit goes straight to the output, never via the shadow.
    assign pub_data = {data_i, shadow_q[NUM_CH-2:0]};
`endif

    assign wr_idx = load1 ? '0 : slot;

    always_comb begin
        state_d    = state_q;
        clr        = 1'b0;
        load1      = 1'b0;
        inc        = 1'b0;
        wr_en      = 1'b0;
        publish    = 1'b0;
        sync_err_d = 1'b0;
        par_err_d  = 1'b0;
        if (bit_valid_i) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_i) begin
                        wr_en   = 1'b1;
                        load1   = 1'b1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_i) begin
                        wr_en      = 1'b1;
                        load1      = 1'b1;
                        sync_err_d = (slot != '0);
                    end else if (slot == '0) begin
                        sync_err_d = 1'b1;
                        clr        = 1'b1;
                        state_d    = HUNT;
                    end else if (slot == LAST) begin
                        inc = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                        if (even_parity(64'(shadow_q)) == data_i)
                            publish = 1'b1;
                        else
                            par_err_d = 1'b1;
`else
                        publish = 1'b1;
`endif
                    end else begin
                        wr_en = 1'b1;
                        inc   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= HUNT;
            shadow_q      <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_valid_q <= publish;
            sync_err_q    <= sync_err_d;
            if (publish)
                ch_data_q <= pub_data;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && wr_idx == SLOT_W'(k))
                    shadow_q[k] <= data_i;
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            par_err_q <= 1'b0;
        else
            par_err_q <= par_err_d;
    end

    assign parity_err_o = par_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign ch_data_o     = ch_data_q;
    assign frame_valid_o = frame_valid_q;
    assign slot_o        = slot;
    assign locked_o      = (state_q == LOCKED);
    assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed scenarios plus random stream vs a frame model.
// Honours TDM_DEMUX_PARITY_EN the same way the design does.
module tb_tdm_demux;

    localparam int NUM_CH = 16;
    localparam int SLOT_W = $clog2(NUM_CH + 1);
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FL = NUM_CH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL = NUM_CH;
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              din = 1'b0;
    logic              bv = 1'b0;
    logic              fr = 1'b0;
    logic [NUM_CH-1:0] ch_data;
    logic              fvalid;
    logic [SLOT_W-1:0] slot;
    logic              locked;
    logic              sync_err;
    logic              par_err;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: a frame is whatever bits have been collected since the sync.
    bit                m_locked = 1'b0;
    bit                q[$];
    logic [NUM_CH-1:0] e_data = '0;
    bit                e_fv = 1'b0;
    bit                e_se = 1'b0;
    bit                e_pe = 1'b0;

    always #5 clk = ~clk;

    tdm_demux #(
        .NUM_CH(NUM_CH),
        .SLOT_W(SLOT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (din),
        .bit_valid_i  (bv),
        .frame_i      (fr),
        .ch_data_o    (ch_data),
        .frame_valid_o(fvalid),
        .slot_o       (slot),
        .locked_o     (locked),
        .sync_err_o   (sync_err),
        .parity_err_o (par_err)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v,
                         input bit f, input bit d);
        logic [NUM_CH-1:0] w;
        e_fv = 0;
        e_se = 0;
        e_pe = 0;
        if (r) begin
            m_locked = 0;
            q.delete();
            e_data = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (f) begin
                    q.delete();
                    q.push_back(d);
                    m_locked = 1;
                end
            end else if (f) begin
                if (q.size() != 0) e_se = 1;
                q.delete();
                q.push_back(d);
            end else if (q.size() == 0) begin
                e_se = 1;
                m_locked = 0;
            end else begin
                q.push_back(d);
                if (q.size() == FL) begin
                    w = '0;
                    for (int i = 0; i < NUM_CH; i++) w[i] = q[i];
                    if (!PAR || q[NUM_CH] == ^w) begin
                        e_data = w;
                        e_fv = 1;
                    end else begin
                        e_pe = 1;
                    end
                    q.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        check("ch_data", 32'(ch_data), 32'(e_data));
        check("frame_valid", 32'(fvalid), 32'(e_fv));
        check("slot", 32'(slot), 32'(q.size()));
        check("locked", 32'(locked), 32'(m_locked));
        check("sync_err", 32'(sync_err), 32'(e_se));
        check("parity_err", 32'(par_err), 32'(e_pe));
    endtask

    task automatic cyc(input bit r, input bit v,
                       input bit f, input bit d);
        rst = r;
        bv  = v;
        fr  = f;
        din = d;
        @(posedge clk);
        model(r, v, f, d);
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [NUM_CH-1:0] w,
                              input bit par_ok);
        for (int i = 0; i < NUM_CH; i++)
            cyc(0, 1, i == 0, w[i]);
        if (PAR)
            cyc(0, 1, 0, par_ok ? ^w : ~^w);
    endtask

    initial begin
        logic [NUM_CH-1:0] w;
        int pos;
        bit f;

        cyc(1, 0, 0, 0);
        check("rst_data", 32'(ch_data), 0);
        check("rst_locked", 32'(locked), 0);

        // Unsynced strobes are ignored.
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 0, 1);
        check("hunt_slot", 32'(slot), 0);

        send_frame(16'hA5C3, 1);
        check("t1_data", 32'(ch_data), 32'h0000_A5C3);
        check("t1_fv", 32'(fvalid), 1);
        cyc(0, 0, 0, 0);
        check("t1_fv_one", 32'(fvalid), 0);
        check("t1_locked", 32'(locked), 1);

        send_frame(16'h1234, 1);
        check("t3_a", 32'(ch_data), 32'h0000_1234);
        send_frame(16'hFFFF, 1);
        check("t3_b", 32'(ch_data), 32'h0000_FFFF);

        // Resync mid-frame at slot 7.
        for (int i = 0; i < 7; i++)
            cyc(0, 1, i == 0, 0);
        send_frame(16'h5A0F, 1);
        check("t4_data", 32'(ch_data), 32'h0000_5A0F);

        // Slot-0 strobe without sync drops lock.
        cyc(0, 1, 0, 1);
        check("t4_unlock", 32'(locked), 0);

        for (int i = 0; i < 9; i++)
            cyc(0, 1, i == 0, 1);
        cyc(1, 1, 0, 1);
        check("t5_data", 32'(ch_data), 0);
        check("t5_slot", 32'(slot), 0);

        if (PAR) begin
            send_frame(16'h0001, 1);
            check("t6_good", 32'(ch_data), 1);
            send_frame(16'h0003, 0);
            check("t6_perr", 32'(par_err), 1);
            check("t6_hold", 32'(ch_data), 1);
        end

        // Random stream: mostly well-formed framing with injected faults.
        pos = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                cyc(1, 0, 0, 0);
                pos = 0;
            end else if ($urandom_range(0, 4) == 0) begin
                cyc(0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
            end else begin
                f = (pos == 0);
                if ($urandom_range(0, 49) == 0) f = ~f;
                cyc(0, 1, f, $urandom_range(0, 1));
                pos = (pos + 1) % FL;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
